// File: rtl/muldiv_if.sv
// Request/response bundle between the EX stage and the multiply/divide unit.
interface muldiv_if #(
    parameter int unsigned XLEN = 32
);
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, op, rs1, rs2, flush,
        input  busy, done, result
    );

    modport slave (
        input  start, op, rs1, rs2, flush,
        output busy, done, result
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and
// restoring divide on operand magnitudes, fixed latency for every op.
module muldiv_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic     clk,
    input  logic     rst_n,
    muldiv_if.slave  bus
);
    localparam int unsigned CW = $clog2(XLEN) + 1;
    localparam int unsigned DW = 2 * XLEN;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic            prep_q, prep_d;
    logic [2:0]      op_q, op_d;
    logic [XLEN-1:0] rs1_q, rs1_d;
    logic [XLEN-1:0] rs2_q, rs2_d;
    logic [DW-1:0]   a_q, a_d;
    logic [DW-1:0]   acc_q, acc_d;
    logic [XLEN-1:0] b_q, b_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [XLEN-1:0] result_q, result_d;

    // Decode / datapath signals
    logic            is_div;
    logic            a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic [DW-1:0]   mul_acc_step, mul_a_step;
    logic [XLEN-1:0] mul_b_step;
    logic [XLEN:0]   rem_sh, divisor_ext, div_rem_step;
    logic            div_ge;
    logic [XLEN-1:0] div_q_step;
    logic [DW-1:0]   prod_fin;
    logic [XLEN-1:0] quo_fin, rem_fin;
    logic            div_zero, div_ovf;
    logic [XLEN-1:0] final_res;
    logic            accept;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    // Operand sign handling and magnitudes from the latched request
    always_comb begin
        is_div   = op_q[2];
        a_signed = (op_q == 3'b001) || (op_q == 3'b010) || (op_q == 3'b100) || (op_q == 3'b110);
        b_signed = (op_q == 3'b001) || (op_q == 3'b100) || (op_q == 3'b110);
        a_neg    = a_signed && rs1_q[XLEN-1];
        b_neg    = b_signed && rs2_q[XLEN-1];
        a_mag    = a_neg ? (~rs1_q + XLEN'(1)) : rs1_q;
        b_mag    = b_neg ? (~rs2_q + XLEN'(1)) : rs2_q;
        div_zero = (rs2_q == '0);
        div_ovf  = ((op_q == 3'b100) || (op_q == 3'b110)) && (rs1_q == MIN_NEG) && (rs2_q == '1);
    end

    // One iteration of shift-add multiply and restoring divide
    always_comb begin
        mul_acc_step = b_q[0] ? (acc_q + a_q) : acc_q;
        mul_a_step   = a_q << 1;
        mul_b_step   = b_q >> 1;
        rem_sh       = {acc_q[XLEN-1:0], b_q[XLEN-1]};
        divisor_ext  = {1'b0, a_q[XLEN-1:0]};
        div_ge       = (rem_sh >= divisor_ext);
        div_rem_step = div_ge ? (rem_sh - divisor_ext) : rem_sh;
        div_q_step   = {b_q[XLEN-2:0], div_ge};
    end

    // Sign fix-up and special-case selection applied on the final iteration
    always_comb begin
        prod_fin = (a_neg ^ b_neg) ? (~mul_acc_step + DW'(1)) : mul_acc_step;
        quo_fin  = (a_neg ^ b_neg) ? (~div_q_step + XLEN'(1)) : div_q_step;
        rem_fin  = a_neg ? (~div_rem_step[XLEN-1:0] + XLEN'(1)) : div_rem_step[XLEN-1:0];
        unique case (op_q)
            3'b000:                 final_res = prod_fin[XLEN-1:0];
            3'b001, 3'b010, 3'b011: final_res = prod_fin[DW-1:XLEN];
            3'b100, 3'b101:         final_res = div_zero ? '1 : (div_ovf ? MIN_NEG : quo_fin);
            default:                final_res = div_zero ? rs1_q : (div_ovf ? '0 : rem_fin);
        endcase
    end

    // Next-state, datapath and output control
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        prep_d   = prep_q;
        op_d     = op_q;
        rs1_d    = rs1_q;
        rs2_d    = rs2_q;
        a_d      = a_q;
        acc_d    = acc_q;
        b_d      = b_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;

        accept = bus.start && !bus.flush && ((state_q == S_IDLE) || (state_q == S_DONE));

        unique case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (accept) begin
                    state_d = S_CALC;
                    count_d = '0;
                    prep_d  = 1'b1;
                    op_d    = bus.op;
                    rs1_d   = bus.rs1;
                    rs2_d   = bus.rs2;
                end
            end
            S_CALC: begin
                if (prep_q) begin
                    // Load magnitudes: divide keeps divisor in a, dividend/quotient in b
                    prep_d = 1'b0;
                    busy_d = 1'b1;
                    acc_d  = '0;
                    a_d    = is_div ? DW'(b_mag) : DW'(a_mag);
                    b_d    = is_div ? a_mag : b_mag;
                end else begin
                    count_d = count_q + CW'(1);
                    if (is_div) begin
                        acc_d = {{(DW-XLEN-1){1'b0}}, div_rem_step};
                        b_d   = div_q_step;
                    end else begin
                        acc_d = mul_acc_step;
                        a_d   = mul_a_step;
                        b_d   = mul_b_step;
                    end
                    if (count_q == CW'(XLEN - 1)) begin
                        state_d  = S_DONE;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                        result_d = final_res;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // Squash wins over everything, including a same-cycle start
        if (bus.flush) begin
            state_d  = S_IDLE;
            prep_d   = 1'b0;
            busy_d   = 1'b0;
            done_d   = 1'b0;
            result_d = result_q;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            prep_q   <= 1'b0;
            op_q     <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            a_q      <= '0;
            acc_q    <= '0;
            b_q      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            prep_q   <= prep_d;
            op_q     <= op_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            a_q      <= a_d;
            acc_q    <= acc_d;
            b_q      <= b_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit.
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    muldiv_if #(.XLEN(32)) bus ();

    muldiv_unit #(.XLEN(32)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    // Compare one observed value against its expected value
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Present a request at the next negedge; returns 1 time unit after the accepting edge
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.rs1   = a;
        bus.rs2   = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.op    = 3'($urandom);
        bus.rs1   = $urandom;
        bus.rs2   = $urandom;
    endtask

    // Wait for done, checking latency, busy width and result; optionally poke start mid-op
    task automatic wait_done(input string tag, input logic [31:0] exp, input int inject_at);
        int n      = 0;
        int busy_n = 0;
        while (bus.done !== 1'b1 && n < 60) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.busy === 1'b1) busy_n++;
            bus.start = (n == inject_at);
            if (n == inject_at) begin
                bus.op  = OP_DIVU;
                bus.rs1 = 32'd9;
                bus.rs2 = 32'd3;
            end
        end
        bus.start = 1'b0;
        check_eq({tag, "_lat"}, 32'(n), 32'd33);
        check_eq({tag, "_busycyc"}, 32'(busy_n), 32'd32);
        check_eq({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
        check_eq({tag, "_res"}, bus.result, exp);
    endtask

    // No done may appear for the given number of cycles
    task automatic check_quiet(input string tag, input int cycles);
        int dones = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) dones++;
        end
        check_eq({tag, "_nodone"}, 32'(dones), 32'd0);
    endtask

    string       v_tag [14] = '{"mul_neg", "mulh_min", "mulhu_max", "mulhsu_max", "mulh_neg",
                                "div_neg", "rem_neg", "rem_negdiv", "divu", "remu",
                                "div_by0", "remu_by0", "div_ovf", "rem_ovf"};
    logic [2:0]  v_op  [14] = '{OP_MUL, OP_MULH, OP_MULHU, OP_MULHSU, OP_MULH,
                                OP_DIV, OP_REM, OP_REM, OP_DIVU, OP_REMU,
                                OP_DIV, OP_REMU, OP_DIV, OP_REM};
    logic [31:0] v_a   [14] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
                                32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'd100, 32'd100,
                                32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] v_b   [14] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd7,
                                32'd2, 32'd2, 32'hFFFF_FFFE, 32'd7, 32'd7,
                                32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] v_exp [14] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd1, 32'd14, 32'd2,
                                32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};

    initial begin
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        bus.op    = '0;
        bus.rs1   = '0;
        bus.rs2   = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_done", 32'(bus.done), 32'd0);
        check_eq("rst_result", bus.result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed arithmetic vectors, including divide-by-zero and signed overflow
        for (int i = 0; i < 14; i++) begin
            issue(v_op[i], v_a[i], v_b[i]);
            wait_done(v_tag[i], v_exp[i], -1);
            @(posedge clk);
            #1;
            check_eq({v_tag[i], "_done_pulse"}, 32'(bus.done), 32'd0);
        end

        // Back-to-back: start during the done cycle
        issue(OP_MUL, 32'd6, 32'd7);
        wait_done("b2b_first", 32'd42, -1);
        bus.start = 1'b1;
        bus.op    = OP_DIVU;
        bus.rs1   = 32'd100;
        bus.rs2   = 32'd7;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check_eq("b2b_done_drop", 32'(bus.done), 32'd0);
        wait_done("b2b_second", 32'd14, -1);

        // start while busy is ignored
        issue(OP_MUL, 32'd3, 32'd5);
        wait_done("busy_start", 32'd15, 5);
        check_quiet("busy_start_after", 40);

        // Flush at cycle 10 of CALC
        issue(OP_MUL, 32'd11, 32'd13);
        repeat (9) @(posedge clk);
        #1;
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        check_eq("flush_busy", 32'(bus.busy), 32'd0);
        check_eq("flush_done", 32'(bus.done), 32'd0);
        check_eq("flush_result_hold", bus.result, 32'd15);
        check_quiet("flush", 40);
        check_eq("flush_result_after", bus.result, 32'd15);
        issue(OP_MUL, 32'd2, 32'd3);
        wait_done("after_flush", 32'd6, -1);

        // start and flush together: start dropped
        @(negedge clk);
        bus.start = 1'b1;
        bus.flush = 1'b1;
        bus.op    = OP_MUL;
        bus.rs1   = 32'd9;
        bus.rs2   = 32'd9;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("startflush_busy", 32'(bus.busy), 32'd0);
        check_quiet("startflush", 40);
        check_eq("startflush_result", bus.result, 32'd6);

        // Asynchronous reset mid-CALC
        issue(OP_DIVU, 32'd1000, 32'd10);
        repeat (5) @(posedge clk);
        #1;
        check_eq("pre_rst_busy", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_busy", 32'(bus.busy), 32'd0);
        check_eq("midrst_done", 32'(bus.done), 32'd0);
        check_eq("midrst_result", bus.result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        check_quiet("midrst", 40);
        issue(OP_DIVU, 32'd1000, 32'd10);
        wait_done("after_rst", 32'd100, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
